// File: rtl/perm_pkg.sv
// Shared definitions for the slice permutation engine: modes, FSM states
// and the bit-index mapping used by the pi permutation network.
package perm_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_PI     = 2'd1;
  localparam logic [1:0] MODE_PI_INV = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Source bit feeding output bit (x + n*y). The inverse solves
  // (y + k*j) mod n == x for j, which is unique when gcd(k, n) == 1.
  function automatic int src_index(input int x, input int y, input int n,
                                   input int k, input bit inverse);
    int sy;
    sy = 0;
    if (!inverse) return ((x + k * y) % n) + n * x;
    for (int j = 0; j < n; j++)
      if (((y + k * j) % n) == x) sy = j;
    return y + n * sy;
  endfunction

endpackage

// File: rtl/slice_pi_permute.sv
// Combinational pi / inverse-pi / bypass permutation of one N x N bit plane.
module slice_pi_permute
  import perm_pkg::*;
#(
  parameter int N    = 5,
  parameter int PI_K = 3
) (
  input  logic [1:0]     mode,
  input  logic [N*N-1:0] slice_in,
  output logic [N*N-1:0] slice_out
);

  if (gcd(PI_K, N) != 1) begin : g_bad_pi_k
    $error("PI_K must be coprime with N");
  end

  logic [N*N-1:0] fwd;
  logic [N*N-1:0] inv;

  for (genvar gx = 0; gx < N; gx++) begin : g_x
    for (genvar gy = 0; gy < N; gy++) begin : g_y
      assign fwd[gx + N*gy] = slice_in[src_index(gx, gy, N, PI_K, 1'b0)];
      assign inv[gx + N*gy] = slice_in[src_index(gx, gy, N, PI_K, 1'b1)];
    end
  end

  always_comb begin
    slice_out = slice_in;
    case (mode)
      MODE_BYPASS: slice_out = slice_in;
      MODE_PI:     slice_out = fwd;
      MODE_PI_INV: slice_out = inv;
      default:     slice_out = slice_in;
    endcase
  end

endmodule

// File: rtl/slice_permute_engine.sv
// Streaming frame engine: accepts DEPTH slices, permutes each and emits
// them in order through a single output register, pulsing done at the end.
//
//   state | meaning
//   IDLE  | waiting for start, handshakes disabled
//   RUN   | frame in progress, slices flow in and out
//   DONE  | last slice delivered, one-cycle done pulse
module slice_permute_engine
  import perm_pkg::*;
#(
  parameter int N     = 5,
  parameter int DEPTH = 64,
  parameter int PI_K  = 3,
  localparam int W    = N * N,
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [IW-1:0] out_idx,
  output logic          busy,
  output logic          done
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("DEPTH must be at least 1");
  end

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state, state_nx;
  logic [1:0]    mode_q;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [W-1:0]  perm_data;
  logic          in_hs;
  logic          out_hs;

  slice_pi_permute #(.N(N), .PI_K(PI_K)) u_permute (
    .mode      (mode_q),
    .slice_in  (in_data),
    .slice_out (perm_data)
  );

  assign in_ready = (state == RUN) && (in_cnt < DEPTH_C) && (!out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (out_hs && (out_cnt == DEPTH_C - 1'b1)) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_BYPASS;
      in_cnt    <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      if (state == IDLE && start) begin
        mode_q  <= mode;
        in_cnt  <= '0;
        out_cnt <= '0;
      end
      if (out_hs) out_cnt <= out_cnt + 1'b1;
      // A same-cycle input refills the register, so out_valid stays high.
      if (in_hs) begin
        out_data  <= perm_data;
        out_idx   <= in_cnt[IW-1:0];
        out_valid <= 1'b1;
        in_cnt    <= in_cnt + 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slice_permute_engine.sv
// Directed bench for slice_permute_engine: known pi vectors, full frames,
// backpressure, mode/start disturbance and reset mid-frame.
module tb_slice_permute_engine;

  localparam int N     = 5;
  localparam int W     = N * N;
  localparam int DEPTH = 64;
  localparam int PI_K  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [5:0]   out_idx;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] src  [DEPTH];
  logic [W-1:0] got  [DEPTH];
  logic [W-1:0] orig [DEPTH];

  slice_permute_engine #(.N(N), .DEPTH(DEPTH), .PI_K(PI_K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference permutation written directly in plane coordinates.
  function automatic logic [W-1:0] model_perm(input logic [1:0] m, input logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
    if (m == 2'd1) begin
      for (int x = 0; x < N; x++)
        for (int y = 0; y < N; y++)
          r[x + N*y] = d[((x + PI_K*y) % N) + N*x];
    end else if (m == 2'd2) begin
      for (int x = 0; x < N; x++)
        for (int y = 0; y < N; y++)
          r[((x + PI_K*y) % N) + N*x] = d[x + N*y];
    end
    return r;
  endfunction

  // Streams src[] through the engine. stall_at: output index where out_ready
  // drops for 5 cycles (-1 none). abort_at: stop once that many outputs seen.
  task automatic run_frame(input logic [1:0] m, input int stall_at, input bit disturb,
                           input int abort_at, input bit streaming);
    int ip, op, stall_n, ndone, first_cyc, last_cyc, cyc;
    bit stall;
    ip = 0; op = 0; stall_n = 0; ndone = 0; first_cyc = -1; last_cyc = -1;
    @(negedge clk);
    start = 1'b1; mode = m; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (disturb) mode = (m == 2'd1) ? 2'd2 : 2'd1;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) @(negedge clk);
      in_valid  = (ip < DEPTH);
      in_data   = (ip < DEPTH) ? src[ip] : '0;
      stall     = (op == stall_at) && (stall_n < 5);
      out_ready = !stall;
      start     = disturb && (cyc == 5 || cyc == 30);
      #1;
      if (stall) begin
        stall_n++;
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_data", {7'd0, out_data}, {7'd0, model_perm(m, src[op])});
        check("stall_out_idx", {26'd0, out_idx}, op);
      end
      if (done) ndone++;
      if (out_valid && out_ready) begin
        check("out_data", {7'd0, out_data}, {7'd0, model_perm(m, src[op])});
        check("out_idx", {26'd0, out_idx}, op);
        got[op] = out_data;
        if (op == 0) first_cyc = cyc;
        last_cyc = cyc;
        op++;
      end
      if (in_valid && in_ready) ip++;
      if (op == abort_at || op == DEPTH) break;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (op != abort_at && op != DEPTH) begin
      check("frame_timeout", op, DEPTH);
      return;
    end
    check("done_during_frame", ndone, 0);
    if (stall_at >= 0) check("stall_cycles", stall_n, 5);
    if (streaming) begin
      check("first_out_latency", first_cyc, 1);
      check("stream_span", last_cyc - first_cyc, DEPTH - 1);
    end
    if (op == abort_at) return;
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    check("out_valid_in_done", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("done_once", {31'd0, done}, 32'd0);
    check("busy_dropped", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_data", {7'd0, out_data}, 32'd0);
    check("rst_out_idx", {26'd0, out_idx}, 32'd0);
    in_valid = 1'b1;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // Forward pi, streaming, with known vectors at the head of the frame.
    for (int i = 0; i < DEPTH; i++) src[i] = W'($urandom);
    src[0] = 25'h0000002;
    src[1] = 25'h0000001;
    for (int i = 0; i < DEPTH; i++) orig[i] = src[i];
    run_frame(2'd1, -1, 1'b0, -1, 1'b1);
    check("fwd_vec_0x2", {7'd0, got[0]}, 32'h0000400);
    check("fwd_fixed_0x1", {7'd0, got[1]}, 32'h0000001);

    // Inverse of the forward output must restore the original slices.
    for (int i = 0; i < DEPTH; i++) src[i] = got[i];
    run_frame(2'd2, -1, 1'b0, -1, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      check("round_trip", {7'd0, got[i]}, {7'd0, orig[i]});

    for (int i = 0; i < DEPTH; i++) src[i] = W'($urandom);
    src[0] = 25'h0000400;
    run_frame(2'd2, -1, 1'b0, -1, 1'b1);
    check("inv_vec_0x400", {7'd0, got[0]}, 32'h0000002);

    // Reserved mode is bypass; mid-frame mode change and start are ignored.
    for (int i = 0; i < DEPTH; i++) src[i] = W'($urandom);
    run_frame(2'd3, -1, 1'b1, -1, 1'b0);
    for (int i = 0; i < DEPTH; i += 9)
      check("mode3_bypass", {7'd0, got[i]}, {7'd0, src[i]});

    // Backpressure mid-frame.
    for (int i = 0; i < DEPTH; i++) src[i] = W'($urandom);
    run_frame(2'd1, 30, 1'b0, -1, 1'b0);

    // Reset after slice 20 has been delivered.
    for (int i = 0; i < DEPTH; i++) src[i] = W'($urandom);
    run_frame(2'd1, -1, 1'b0, 21, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_out_idx", {26'd0, out_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_frame(2'd1, -1, 1'b0, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
